// File: rtl/sr_latch_seq.sv
// Round-robin sequencer driving a bank of NAND SR latches with fixed-width active-low
// pulses, one channel at a time, then verifying the latch Q against the command.
module sr_latch_seq #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned PULSE_W = 3,
  parameter int unsigned GAP_W   = 1,
  localparam int unsigned CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] set_req,
  input  logic [N_CH-1:0] clr_req,
  input  logic [N_CH-1:0] q_fb,
  output logic [N_CH-1:0] Sbar,
  output logic [N_CH-1:0] Rbar,
  output logic            busy,
  output logic [CW-1:0]   grant_ch,
  output logic            done,
  output logic            err_mismatch,
  output logic            err_conflict
);

  localparam int unsigned CNTW = 8;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              cmd_q, cmd_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [N_CH-1:0]   pend_set_q, pend_set_d;
  logic [N_CH-1:0]   pend_clr_q, pend_clr_d;
  logic [N_CH-1:0]   sbar_d, rbar_d;
  logic [CW-1:0]     grant_d;
  logic              busy_d, done_d, errm_d, errc_d;

  logic [N_CH-1:0]   pending;
  logic              found;
  logic [CW-1:0]     pick;
  logic [CW-1:0]     cand;
  int unsigned       idx;

  assign pending = pend_set_q | pend_clr_q;

  // First pending channel at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = CW'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    rr_d       = rr_q;
    grant_d    = grant_ch;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;
    sbar_d     = '1;
    rbar_d     = '1;
    done_d     = 1'b0;
    errm_d     = 1'b0;
    errc_d     = |(set_req & clr_req);

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d          = pick;
          cmd_d            = pend_set_q[pick];
          pend_set_d[pick] = 1'b0;
          pend_clr_d[pick] = 1'b0;
          rr_d             = (pick == CW'(N_CH - 1)) ? '0 : pick + CW'(1);
          cnt_d            = CNTW'(PULSE_W - 1);
          if (pend_set_q[pick]) sbar_d[pick] = 1'b0;
          else                  rbar_d[pick] = 1'b0;
          state_d          = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = CNTW'(GAP_W - 1);
          state_d = GAP;
        end else begin
          cnt_d  = cnt_q - CNTW'(1);
          sbar_d = Sbar;
          rbar_d = Rbar;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          errm_d  = (q_fb[grant_ch] != cmd_q);
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // New requests override the grant-time clear, so a re-request of the
    // channel in service is kept for a later turn.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (set_req[i] && clr_req[i]) begin
        pend_set_d[i] = 1'b0;
        pend_clr_d[i] = 1'b0;
      end else if (set_req[i]) begin
        pend_set_d[i] = 1'b1;
        pend_clr_d[i] = 1'b0;
      end else if (clr_req[i]) begin
        pend_set_d[i] = 1'b0;
        pend_clr_d[i] = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= 1'b0;
      rr_q         <= '0;
      pend_set_q   <= '0;
      pend_clr_q   <= '0;
      Sbar         <= '1;
      Rbar         <= '1;
      busy         <= 1'b0;
      grant_ch     <= '0;
      done         <= 1'b0;
      err_mismatch <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      rr_q         <= rr_d;
      pend_set_q   <= pend_set_d;
      pend_clr_q   <= pend_clr_d;
      Sbar         <= sbar_d;
      Rbar         <= rbar_d;
      busy         <= busy_d;
      grant_ch     <= grant_d;
      done         <= done_d;
      err_mismatch <= errm_d;
      err_conflict <= errc_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_seq.sv
// Bench for sr_latch_seq: directed scenarios plus random requests, compared every cycle
// against a time-since-grant reference model and a behavioural NAND latch bank.
module tb_sr_latch_seq;

  localparam int N  = 4;
  localparam int PW = 3;
  localparam int GW = 1;
  localparam int OP = PW + GW + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] set_req = '0;
  logic [N-1:0] clr_req = '0;
  logic [N-1:0] q_fb;
  logic [N-1:0] Sbar, Rbar;
  logic         busy, done, err_mismatch, err_conflict;
  logic [1:0]   grant_ch;

  logic [N-1:0] lq = '0;
  logic [N-1:0] stuck_en = '0;
  logic [N-1:0] stuck_val = '0;

  int n_chk = 0;
  int n_fail = 0;

  sr_latch_seq #(.N_CH(N), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
    .Sbar(Sbar), .Rbar(Rbar), .busy(busy), .grant_ch(grant_ch), .done(done),
    .err_mismatch(err_mismatch), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  // Cross-coupled NAND latch behaviour: low Sbar sets, low Rbar resets.
  always @(Sbar or Rbar) begin
    for (int i = 0; i < N; i++) begin
      if (Sbar[i] === 1'b0)      lq[i] = 1'b1;
      else if (Rbar[i] === 1'b0) lq[i] = 1'b0;
    end
  end
  assign q_fb = (lq & ~stuck_en) | (stuck_val & stuck_en);

  // Reference model: pending sets, pointer, and the age of the current operation.
  logic [N-1:0] m_pset = '0, m_pclr = '0, m_q = '0;
  int           m_rr = 0, m_t = 0, m_ch = 0;
  bit           m_act = 0, m_cmd = 0;
  logic [N-1:0] e_sbar = '1, e_rbar = '1;
  logic         e_busy = 0, e_done = 0, e_errm = 0, e_errc = 0;
  int           e_grant = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] s, input logic [N-1:0] c);
    logic [N-1:0] qe;
    if (r) begin
      m_pset = '0; m_pclr = '0; m_rr = 0; m_act = 0; m_t = 0;
      e_sbar = '1; e_rbar = '1; e_busy = 0; e_grant = 0;
      e_done = 0; e_errm = 0; e_errc = 0;
      return;
    end
    if (m_act) begin
      m_t++;
      if (m_t == OP) m_act = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!m_act && (m_pset[i] || m_pclr[i])) begin
          m_act = 1; m_t = 1; m_ch = i; m_cmd = m_pset[i];
          m_pset[i] = 0; m_pclr[i] = 0;
          m_rr = (i + 1) % N;
          m_q[i] = m_cmd;
          e_grant = i;
        end
      end
    end
    e_sbar = '1; e_rbar = '1;
    if (m_act && m_t <= PW) begin
      if (m_cmd) e_sbar[m_ch] = 1'b0;
      else       e_rbar[m_ch] = 1'b0;
    end
    e_busy = m_act;
    e_done = m_act && (m_t == PW + GW + 1);
    qe     = (m_q & ~stuck_en) | (stuck_val & stuck_en);
    e_errm = e_done && (qe[m_ch] != m_cmd);
    e_errc = |(s & c);
    for (int i = 0; i < N; i++) begin
      if (s[i] && c[i])  begin m_pset[i] = 0; m_pclr[i] = 0; end
      else if (s[i])     begin m_pset[i] = 1; m_pclr[i] = 0; end
      else if (c[i])     begin m_pset[i] = 0; m_pclr[i] = 1; end
    end
  endtask

  task automatic tick(input logic r, input logic [N-1:0] s, input logic [N-1:0] c);
    @(negedge clk);
    rst = r; set_req = s; clr_req = c;
    @(posedge clk);
    model_step(r, s, c);
    #1;
    chk("Sbar", 32'(Sbar), 32'(e_sbar));
    chk("Rbar", 32'(Rbar), 32'(e_rbar));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_ch", 32'(grant_ch), 32'(e_grant));
    chk("done", 32'(done), 32'(e_done));
    chk("err_mismatch", 32'(err_mismatch), 32'(e_errm));
    chk("err_conflict", 32'(err_conflict), 32'(e_errc));
    chk("single_low_line", 32'($countones(~{Sbar, Rbar}) <= 1), 32'(1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, '0);
  endtask

  initial begin
    logic [N-1:0] s, c;
    for (int k = 0; k < 3; k++) tick(1'b1, '0, '0);
    idle(20);

    tick(1'b0, 4'b0100, '0);
    idle(8);

    tick(1'b0, 4'b1111, '0);
    idle(4 * OP + 2);

    tick(1'b0, 4'b0010, 4'b0010);
    idle(8);

    stuck_en = 4'b1000; stuck_val = 4'b1000;
    tick(1'b0, '0, 4'b1000);
    idle(8);
    stuck_en = '0;

    // Reset lands in the second pulse cycle of a set on ch0, with ch2 still pending.
    tick(1'b0, 4'b0101, '0);
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    tick(1'b1, '0, '0);
    idle(12);

    for (int n = 0; n < 3000; n++) begin
      s = 4'($urandom) & 4'($urandom);
      c = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 3) != 0) begin s = '0; c = '0; end
      if ($urandom_range(0, 63) == 0) begin
        stuck_en = 4'($urandom); stuck_val = 4'($urandom);
      end
      tick($urandom_range(0, 127) == 0, s, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
